// File: rtl/half_adder.sv
// Multi-lane half adder: zero-latency combinational sum/carry per lane, an
// in_valid-qualified registered copy of the result, and a saturating counter
// of how many lanes have produced a carry on valid cycles.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clear,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  // Width needed to hold a popcount of 0..WIDTH carries.
  localparam int POP_W = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  // Accumulator is one bit wider than the larger operand so the add never
  // overflows before the saturation compare.
  localparam int ACC_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [POP_W-1:0] carry_pop;
  logic [ACC_W-1:0] count_acc;
  logic [ACC_W-1:0] count_max;
  logic [CNT_W-1:0] count_next;

  // Lanes are independent bitwise ops; no carry ripples between lanes.
  assign sum       = a ^ b;
  assign carry_out = a & b;

  assign count_max = {{(ACC_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  // Popcount of the current carries and saturated next counter value.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    carry_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry_pop = carry_pop + POP_W'(carry_out[i]);
    end
    count_acc = {{(ACC_W - CNT_W){1'b0}}, carry_count}
              + {{(ACC_W - POP_W){1'b0}}, carry_pop};
    count_next = (count_acc > count_max) ? {CNT_W{1'b1}} : count_acc[CNT_W-1:0];
  end

  // Registered result: capture on valid cycles, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else if (in_valid) begin
      sum_q   <= sum;
      carry_q <= carry_out;
    end
  end

  // Valid flag follows in_valid with one cycle of latency, no backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Saturating carry counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_count <= '0;
    end else if (cnt_clear) begin
      carry_count <= '0;
    end else if (in_valid) begin
      carry_count <= count_next;
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: directed steps on a 1-lane instance with a 2-bit
// counter, then randomized traffic on a 4-lane instance scored against an
// arithmetic reference model.
module tb_half_adder;

  localparam int W4 = 4;
  localparam int C4 = 16;
  localparam int C1 = 2;

  logic clk = 1'b0;
  logic rst;

  // 1-lane instance, 2-bit counter
  logic             a1, b1, v1, clr1;
  logic             sum1, co1, sq1, cq1, ov1;
  logic [C1-1:0]    cnt1;

  // 4-lane instance, 16-bit counter
  logic [W4-1:0]    a4, b4;
  logic             v4, clr4;
  logic [W4-1:0]    sum4, co4, sq4, cq4;
  logic             ov4;
  logic [C4-1:0]    cnt4;

  int checks = 0;
  int errors = 0;

  // reference model state for the 4-lane instance
  int exp_sq4, exp_cq4, exp_ov4, exp_cnt4;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(C1)) u_sat (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1), .cnt_clear(clr1),
    .sum(sum1), .carry_out(co1), .sum_q(sq1), .carry_q(cq1),
    .out_valid(ov1), .carry_count(cnt1)
  );

  half_adder #(.WIDTH(W4), .CNT_W(C4)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4), .cnt_clear(clr4),
    .sum(sum4), .carry_out(co4), .sum_q(sq4), .carry_q(cq4),
    .out_valid(ov4), .carry_count(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lane-wise arithmetic: sum digit and carry digit of a[i]+b[i]
  function automatic int model_sum(input int av, input int bv);
    int r = 0;
    for (int i = 0; i < W4; i++) r += (((av >> i) & 1) + ((bv >> i) & 1)) % 2 << i;
    return r;
  endfunction

  function automatic int model_carry(input int av, input int bv);
    int r = 0;
    for (int i = 0; i < W4; i++) r += (((av >> i) & 1) + ((bv >> i) & 1)) / 2 << i;
    return r;
  endfunction

  function automatic int model_ncarry(input int av, input int bv);
    int n = 0;
    for (int i = 0; i < W4; i++) if (((av >> i) & 1) + ((bv >> i) & 1) == 2) n++;
    return n;
  endfunction

  // drive one 4-lane transaction, check combinational and registered outputs
  task automatic w4_step(input int av, input int bv, input bit vv, input bit cv, input string tag);
    a4 = W4'(av); b4 = W4'(bv); v4 = vv; clr4 = cv;
    #1;
    check({tag, "_sum"},   32'(sum4), 32'(model_sum(av, bv)));
    check({tag, "_carry"}, 32'(co4),  32'(model_carry(av, bv)));
    if (vv) begin
      exp_sq4 = model_sum(av, bv);
      exp_cq4 = model_carry(av, bv);
    end
    exp_ov4 = vv;
    if (cv) exp_cnt4 = 0;
    else if (vv) begin
      exp_cnt4 += model_ncarry(av, bv);
      if (exp_cnt4 > (1 << C4) - 1) exp_cnt4 = (1 << C4) - 1;
    end
    tick();
    check({tag, "_sum_q"},   32'(sq4),  32'(exp_sq4));
    check({tag, "_carry_q"}, 32'(cq4),  32'(exp_cq4));
    check({tag, "_ov"},      32'(ov4),  32'(exp_ov4));
    check({tag, "_cnt"},     32'(cnt4), 32'(exp_cnt4));
  endtask

  initial begin
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    int ab_seq[4][3] = '{'{0, 0, 0}, '{0, 1, 1}, '{1, 0, 1}, '{1, 1, 2}};

    rst = 1'b1;
    a1 = 0; b1 = 0; v1 = 0; clr1 = 0;
    a4 = '0; b4 = '0; v4 = 0; clr4 = 0;
    #1;
    check("rst_sq1",  32'(sq1),  0);
    check("rst_cq1",  32'(cq1),  0);
    check("rst_ov1",  32'(ov1),  0);
    check("rst_cnt1", 32'(cnt1), 0);
    check("rst_sq4",  32'(sq4),  0);
    check("rst_ov4",  32'(ov4),  0);
    check("rst_cnt4", 32'(cnt4), 0);

    // combinational path follows inputs while reset is held
    a1 = 1; b1 = 1;
    #1;
    check("rst_comb_sum",   32'(sum1), 0);
    check("rst_comb_carry", 32'(co1),  1);
    tick();
    check("rst_hold_cnt", 32'(cnt1), 0);
    check("rst_hold_cq",  32'(cq1),  0);

    @(negedge clk);
    rst = 1'b0;
    a1 = 0; b1 = 0;

    // combinational truth table at 100 ns steps
    for (int i = 0; i < 4; i++) begin
      a1 = ab_seq[i][0][0]; b1 = ab_seq[i][1][0];
      #1;
      check($sformatf("tt%0d_sum", i),   32'(sum1), 32'(ab_seq[i][2] % 2));
      check($sformatf("tt%0d_carry", i), 32'(co1),  32'(ab_seq[i][2] / 2));
      #99;
    end

    // one valid 1+1, then an idle edge that must hold the result
    @(negedge clk);
    a1 = 1; b1 = 1; v1 = 1;
    tick();
    check("v1_sq",  32'(sq1),  0);
    check("v1_cq",  32'(cq1),  1);
    check("v1_ov",  32'(ov1),  1);
    check("v1_cnt", 32'(cnt1), 1);
    a1 = 0; b1 = 1; v1 = 0;
    tick();
    check("idle_sq",  32'(sq1),  0);
    check("idle_cq",  32'(cq1),  1);
    check("idle_ov",  32'(ov1),  0);
    check("idle_cnt", 32'(cnt1), 1);

    // clear has priority over a same-edge increment
    a1 = 1; b1 = 1; v1 = 1; clr1 = 1;
    tick();
    check("clr_prio_cnt", 32'(cnt1), 0);
    clr1 = 0;

    // saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat%0d_cnt", i), 32'(cnt1), 32'(sat_exp[i]));
    end
    clr1 = 1;
    tick();
    check("sat_clr_cnt", 32'(cnt1), 0);
    clr1 = 0;
    for (int i = 0; i < 3; i++) tick();
    check("pre_pulse_cnt", 32'(cnt1), 3);
    check("pre_pulse_ov",  32'(ov1),  1);

    // asynchronous reset pulse between edges
    #1 rst = 1'b1;
    #1;
    check("pulse_cnt",   32'(cnt1), 0);
    check("pulse_ov",    32'(ov1),  0);
    check("pulse_cq",    32'(cq1),  0);
    check("pulse_sum",   32'(sum1), 0);
    check("pulse_carry", 32'(co1),  1);
    #1 rst = 1'b0;
    #1;
    check("post_pulse_cnt", 32'(cnt1), 0);
    tick();
    check("first_edge_cnt", 32'(cnt1), 1);
    check("first_edge_ov",  32'(ov1),  1);
    v1 = 0;

    // 4-lane directed vector, then randomized traffic
    exp_sq4 = 0; exp_cq4 = 0; exp_ov4 = 0; exp_cnt4 = 0;
    w4_step(4'b1111, 4'b1010, 1'b1, 1'b0, "w4_dir");
    for (int n = 0; n < 300; n++) begin
      w4_step(int'($urandom_range(15)), int'($urandom_range(15)),
              $urandom_range(3) != 0, $urandom_range(19) == 0,
              $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
